// File: rtl/timer_multi_pkg.sv
// Shared register offsets, mode encodings and CTRL bit positions for the
// multi-channel timer.
package timer_multi_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IE       = 3;
  localparam int CTRL_PSC_LSB  = 8;
endpackage

// File: rtl/timer_channel.sv
// One timer channel: control fields, prescaler, down-counter and sticky
// pending flag, with decoded write strobes from the shared register window.
module timer_channel
  import timer_multi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_ctrl,
  input  logic             wr_preset,
  input  logic             wr_status,
  input  logic [31:0]      din,
  output logic [31:0]      ctrl_rd,
  output logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] count,
  output logic             pending,
  output logic             irq
);
  logic             en, ie;
  logic [1:0]       mode;
  logic [PSC_W-1:0] psc, psc_cnt;
  logic             tick, term;
  logic             unused_din;

  assign unused_din = ^din;
  assign tick = en && (psc_cnt == psc);
  // A PRESET write in the same cycle swallows the tick, so no event either.
  assign term = tick && (count == WIDTH'(1)) && !wr_preset;

  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      ie      <= 1'b0;
      mode    <= MODE_ONESHOT;
      psc     <= '0;
      psc_cnt <= '0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_ctrl || wr_preset || !en || tick) psc_cnt <= '0;
      else                                     psc_cnt <= psc_cnt + PSC_W'(1);

      if (wr_preset) begin
        preset <= din[WIDTH-1:0];
        count  <= din[WIDTH-1:0];
        en     <= 1'b1;
      end else if (tick) begin
        if (count > WIDTH'(1)) count <= count - WIDTH'(1);
        else if (count == WIDTH'(1)) begin
          if (mode == MODE_RELOAD) count <= preset;
          else begin
            count <= '0;
            en    <= 1'b0;
          end
        end else en <= 1'b0;
      end

      // Later assignment lets a CTRL write override en/mode from a terminal event.
      if (wr_ctrl) begin
        en   <= din[CTRL_EN];
        mode <= din[CTRL_MODE_MSB:CTRL_MODE_LSB];
        ie   <= din[CTRL_IE];
        psc  <= din[CTRL_PSC_LSB +: PSC_W];
      end

      if (term)                  pending <= 1'b1;
      else if (wr_status && din[0]) pending <= 1'b0;
    end
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN]                     = en;
    ctrl_rd[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode;
    ctrl_rd[CTRL_IE]                     = ie;
    ctrl_rd[CTRL_PSC_LSB +: PSC_W]       = psc;
  end

  assign irq = pending & ie;
endmodule

// File: rtl/timer_multi.sv
// NCH-channel timer behind one register window: addr[5:2] picks the channel,
// addr[1:0] the register. Out-of-range channels read 0 and ignore writes.
module timer_multi
  import timer_multi_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int PSC_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [5:0]     addr,
  input  logic           we,
  input  logic [31:0]    din,
  output logic [31:0]    dout,
  output logic           irq,
  output logic [NCH-1:0] irq_vec
);
  logic [3:0]                ch;
  logic [1:0]                rsel;
  logic [NCH-1:0][31:0]      ctrl_rd, preset_rd, count_rd;
  logic [NCH-1:0]            pend;

  assign ch   = addr[5:2];
  assign rsel = addr[1:0];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic             sel;
    logic [WIDTH-1:0] preset, count;

    assign sel = we && (ch == 4'(i));

    timer_channel #(.WIDTH(WIDTH), .PSC_W(PSC_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_ctrl   (sel && (rsel == REG_CTRL)),
      .wr_preset (sel && (rsel == REG_PRESET)),
      .wr_status (sel && (rsel == REG_STATUS)),
      .din       (din),
      .ctrl_rd   (ctrl_rd[i]),
      .preset    (preset),
      .count     (count),
      .pending   (pend[i]),
      .irq       (irq_vec[i])
    );

    assign preset_rd[i] = 32'(preset);
    assign count_rd[i]  = 32'(count);
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch == 4'(i)) begin
        case (rsel)
          REG_CTRL:   dout = ctrl_rd[i];
          REG_PRESET: dout = preset_rd[i];
          REG_COUNT:  dout = count_rd[i];
          default:    dout = {31'b0, pend[i]};
        endcase
      end
    end
  end

  assign irq = |irq_vec;
endmodule

// File: tb/tb_timer_multi.sv
// Directed-vector bench for timer_multi (NCH=4) with hand-computed expectations.
module tb_timer_multi;
  logic        clk = 1'b0, rst = 1'b1, we = 1'b0;
  logic [5:0]  addr = '0;
  logic [31:0] din = '0, dout;
  logic        irq;
  logic [3:0]  irq_vec;
  logic [31:0] v;
  int nvec = 0, nerr = 0;

  localparam int CTRL = 0, PRESET = 1, COUNT = 2, STATUS = 3;

  always #5 clk = ~clk;

  timer_multi #(.NCH(4), .WIDTH(32), .PSC_W(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .din(din),
    .dout(dout), .irq(irq), .irq_vec(irq_vec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input int c, input int r, input logic [31:0] d);
    addr = {c[3:0], r[1:0]};
    din  = d;
    we   = 1'b1;
    @(posedge clk); #1;
    we   = 1'b0;
    din  = '0;
  endtask

  task automatic rd(input int c, input int r, output logic [31:0] q);
    addr = {c[3:0], r[1:0]};
    #1;
    q = dout;
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    chk("rst_irq", irq, 1'b0);
    chk("rst_vec", irq_vec, 4'b0000);
    rd(0, CTRL, v);  chk("rst_ctrl", v, 32'h0);
    rd(0, COUNT, v); chk("rst_count", v, 32'h0);

    // one-shot, psc=0
    wr(0, CTRL, 32'h8);
    wr(0, PRESET, 32'd3);
    rd(0, COUNT, v); chk("os_c3", v, 32'd3);
    tick; rd(0, COUNT, v); chk("os_c2", v, 32'd2); chk("os_irq0a", irq, 1'b0);
    tick; rd(0, COUNT, v); chk("os_c1", v, 32'd1); chk("os_irq0b", irq, 1'b0);
    tick; rd(0, COUNT, v); chk("os_c0", v, 32'd0);
    chk("os_irq1", irq, 1'b1);
    chk("os_vec", irq_vec, 4'b0001);
    rd(0, CTRL, v); chk("os_en0", v, 32'h8);
    tick; rd(0, COUNT, v); chk("os_hold0", v, 32'd0);
    wr(0, STATUS, 32'h1); chk("os_w1c", irq, 1'b0);

    // auto-reload, psc=2, period 6
    wr(1, CTRL, 32'h20A);
    wr(1, PRESET, 32'd2);
    rd(1, COUNT, v); chk("ar_c2a", v, 32'd2);
    tick(3); rd(1, COUNT, v); chk("ar_c1", v, 32'd1);
    tick(3); rd(1, COUNT, v); chk("ar_reload", v, 32'd2);
    chk("ar_vec1", irq_vec, 4'b0010);
    tick; chk("ar_sticky", irq_vec, 4'b0010);
    wr(1, STATUS, 32'h1); chk("ar_w1c", irq, 1'b0);
    tick(4); chk("ar_vec2", irq_vec, 4'b0010);
    rd(1, COUNT, v); chk("ar_c2b", v, 32'd2);
    wr(1, CTRL, 32'h0);
    wr(1, STATUS, 32'h1); chk("ar_off", irq, 1'b0);

    // channel independence
    wr(2, CTRL, 32'h8);
    wr(3, CTRL, 32'h8);
    wr(2, PRESET, 32'd5);
    wr(3, PRESET, 32'd2);
    chk("ind_v0", irq_vec, 4'b0000);
    tick(2); chk("ind_v8", irq_vec, 4'b1000);
    tick(2); chk("ind_vC", irq_vec, 4'b1100);
    wr(3, STATUS, 32'h1); chk("ind_v4", irq_vec, 4'b0100); chk("ind_irq", irq, 1'b1);
    wr(2, STATUS, 32'h1); chk("ind_clr", irq, 1'b0);

    // W1C colliding with terminal event
    wr(0, PRESET, 32'd2);
    tick;
    wr(0, STATUS, 32'h1); chk("col_w1c", irq_vec, 4'b0001);
    wr(0, STATUS, 32'h1); chk("col_clr", irq_vec, 4'b0000);

    // PRESET write colliding with a tick
    wr(0, PRESET, 32'd10);
    wr(0, PRESET, 32'd7);
    rd(0, COUNT, v); chk("col_pre", v, 32'd7);
    tick; rd(0, COUNT, v); chk("col_pre_dec", v, 32'd6);
    wr(0, CTRL, 32'h0);

    // PRESET=0: en clears after one tick, no event
    wr(0, CTRL, 32'h8);
    wr(0, PRESET, 32'd0);
    rd(0, CTRL, v); chk("p0_en1", v, 32'h9);
    tick; rd(0, CTRL, v); chk("p0_en0", v, 32'h8);
    chk("p0_irq", irq, 1'b0);
    rd(0, STATUS, v); chk("p0_pend", v, 32'h0);

    // event with ie=0, then unmask
    wr(0, CTRL, 32'h0);
    wr(0, PRESET, 32'd1);
    tick; chk("ie0_irq", irq, 1'b0);
    rd(0, STATUS, v); chk("ie0_pend", v, 32'h1);
    rd(0, CTRL, v); chk("ie0_en", v, 32'h0);
    wr(0, CTRL, 32'h8); chk("ie1_irq", irq, 1'b1); chk("ie1_vec", irq_vec, 4'b0001);
    wr(0, STATUS, 32'h2); chk("w1c_bit1", irq, 1'b1);
    wr(0, STATUS, 32'h1); chk("w1c_bit0", irq, 1'b0);

    // channel 9 does not exist
    rd(9, CTRL, v); chk("ch9_ctrl", v, 32'h0);
    wr(9, PRESET, 32'h55);
    rd(9, PRESET, v); chk("ch9_pre", v, 32'h0);
    rd(1, PRESET, v); chk("ch9_alias_pre", v, 32'd2);
    rd(1, CTRL, v);   chk("ch9_alias_ctrl", v, 32'h0);
    rd(1, COUNT, v);  chk("ch9_alias_cnt", v, 32'd2);

    // reset mid-count with a pending flag set
    wr(3, CTRL, 32'h8);
    wr(3, PRESET, 32'd1);
    wr(2, CTRL, 32'h8);
    chk("rm_irq1", irq, 1'b1);
    wr(2, PRESET, 32'd100);
    tick(2); rd(2, COUNT, v); chk("rm_c98", v, 32'd98);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rm_irq0", irq, 1'b0);
    chk("rm_vec0", irq_vec, 4'b0000);
    rd(2, COUNT, v);  chk("rm_cnt", v, 32'h0);
    rd(2, PRESET, v); chk("rm_pre", v, 32'h0);
    rd(2, CTRL, v);   chk("rm_ctrl", v, 32'h0);
    rd(3, STATUS, v); chk("rm_pend", v, 32'h0);
    rd(1, PRESET, v); chk("rm_pre1", v, 32'h0);
    tick; rd(2, COUNT, v); chk("rm_hold", v, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
